// File: rtl/platformer_pkg.sv
// Shared definitions for the platformer input path: key bit positions and the
// direction-resolution state encoding.
package platformer_pkg;

  // Bit positions within the raw key_n bus
  localparam int unsigned KEY_RIGHT = 0;
  localparam int unsigned KEY_JUMP  = 1;
  localparam int unsigned KEY_LEFT  = 2;
  localparam int unsigned NUM_KEYS  = 3;

  // Direction resolver state
  typedef enum logic [1:0] {
    DIR_IDLE  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2
  } dir_state_e;

endpackage : platformer_pkg

// File: rtl/key_debouncer.sv
// Two-flop synchronizer plus counter debouncer for one active-low button.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   key_n         raw button, low = pressed
//   stable        debounced level, same polarity as key_n (1 = released)
//   rise          one-cycle pulse, registered with the edge where stable
//                 changes from released to pressed
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic stable,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive cycles where the synced key disagrees with stable;
  // any agreement (a bounce back) clears the count.
  always_comb begin
    stable_d = stable_q;
    rise_d   = 1'b0;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        rise_d   = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchronizer resets to released so leaving reset never looks like a press
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= key_n;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;

endmodule : key_debouncer

// File: rtl/platform_input_conditioner.sv
// Turns raw active-low buttons into clean player controls: debounced levels,
// left/right resolved so at most one is active, and a jump request latched
// until the next game_tick consumes it.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   key_n[2:0]        raw buttons, low = pressed (0 right, 1 jump, 2 left)
//   game_tick         60 Hz strobe; consumer samples jump_req in that cycle
//   move_left/right   resolved direction requests (never both 1)
//   jump              debounced jump level
//   jump_req          latched jump press, cleared by a consuming game_tick
//   any_input_level   OR of all debounced levels before resolution
module platform_input_conditioner
  import platformer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] key_n,
  input  logic       game_tick,
  output logic       move_left,
  output logic       move_right,
  output logic       jump,
  output logic       jump_req,
  output logic       any_input_level
);

  logic [NUM_KEYS-1:0] stable_n;
  logic [NUM_KEYS-1:0] rise;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk   (clk),
      .rst   (rst),
      .key_n (key_n[i]),
      .stable(stable_n[i]),
      .rise  (rise[i])
    );
  end

  logic left_lvl, right_lvl;
  assign left_lvl  = ~stable_n[KEY_LEFT];
  assign right_lvl = ~stable_n[KEY_RIGHT];

  dir_state_e dir_q, dir_d;
  logic move_left_q, move_left_d, move_right_q, move_right_d;
  logic jump_q, jump_d, jump_req_q, jump_req_d, any_q, any_d;

  // Newest press wins; on release of the owner, fall back to the other key
  always_comb begin
    dir_d = dir_q;
    if (rise[KEY_LEFT] && rise[KEY_RIGHT]) begin
      if (dir_q == DIR_IDLE) begin
        dir_d = (left_lvl || right_lvl) ? DIR_RIGHT : DIR_IDLE;
      end
    end else if (rise[KEY_LEFT]) begin
      dir_d = DIR_LEFT;
    end else if (rise[KEY_RIGHT]) begin
      dir_d = DIR_RIGHT;
    end else begin
      case (dir_q)
        DIR_IDLE:  ;
        DIR_LEFT:  if (!left_lvl)  dir_d = right_lvl ? DIR_RIGHT : DIR_IDLE;
        DIR_RIGHT: if (!right_lvl) dir_d = left_lvl  ? DIR_LEFT  : DIR_IDLE;
        default:   dir_d = DIR_IDLE;
      endcase
    end

    move_left_d  = (dir_d == DIR_LEFT);
    move_right_d = (dir_d == DIR_RIGHT);
    jump_d       = ~stable_n[KEY_JUMP];
    any_d        = ~(&stable_n);
    // A new press outranks the consuming tick so it is never lost
    jump_req_d   = rise[KEY_JUMP] | (jump_req_q & ~game_tick);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_q        <= DIR_IDLE;
      move_left_q  <= 1'b0;
      move_right_q <= 1'b0;
      jump_q       <= 1'b0;
      jump_req_q   <= 1'b0;
      any_q        <= 1'b0;
    end else begin
      dir_q        <= dir_d;
      move_left_q  <= move_left_d;
      move_right_q <= move_right_d;
      jump_q       <= jump_d;
      jump_req_q   <= jump_req_d;
      any_q        <= any_d;
    end
  end

  assign move_left       = move_left_q;
  assign move_right      = move_right_q;
  assign jump            = jump_q;
  assign jump_req        = jump_req_q;
  assign any_input_level = any_q;

endmodule : platform_input_conditioner

// File: tb/tb_platform_input_conditioner.sv
// Bench for platform_input_conditioner with DEBOUNCE_CYCLES=4. A reference
// model predicts the output vector at every clock edge into a scoreboard
// queue; a monitor pops and compares at each falling edge. Directed scenarios
// add point checks against fixed expected values.
module tb_platform_input_conditioner;

  localparam int unsigned DEB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] key_n = 3'b111;
  logic       game_tick = 1'b0;
  logic       move_left, move_right, jump, jump_req, any_input_level;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  platform_input_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .key_n          (key_n),
    .game_tick      (game_tick),
    .move_left      (move_left),
    .move_right     (move_right),
    .jump           (jump),
    .jump_req       (jump_req),
    .any_input_level(any_input_level)
  );

  // ---------------- reference model ----------------
  // Raw key passes through a two-stage delay; a key's debounced level flips
  // once the last DEB delayed samples all disagree with it. Direction goes to
  // the most recently pressed held key.
  logic [2:0] m_s1 = 3'b111, m_s2 = 3'b111;
  logic [2:0] m_deb = 3'b111;   // debounced, 1 = released
  logic [2:0] m_rise = 3'b000;  // press edges produced at the previous edge
  logic [2:0] m_win[$];         // recent delayed samples
  int         m_owner = 0;      // 0 none, 1 left, 2 right
  logic       m_jreq = 1'b0;
  logic [4:0] sb[$];            // {ml, mr, jump, jump_req, any}

  task automatic model_edge(input logic [2:0] kn, input logic tick, input logic rst_lvl);
    logic [4:0] e;
    logic [2:0] nd;
    logic       lp, rp;
    bit         all_diff;
    if (!rst_lvl) begin
      m_s1 = 3'b111; m_s2 = 3'b111; m_deb = 3'b111; m_rise = 3'b000;
      m_win.delete(); m_owner = 0; m_jreq = 1'b0;
      e = 5'b0;
    end else begin
      lp = ~m_deb[2];
      rp = ~m_deb[0];
      if (m_rise[2] && m_rise[0]) begin
        if (m_owner == 0) m_owner = (lp || rp) ? 2 : 0;
      end else if (m_rise[2]) m_owner = 1;
      else if (m_rise[0]) m_owner = 2;
      else if (m_owner == 1 && !lp) m_owner = rp ? 2 : 0;
      else if (m_owner == 2 && !rp) m_owner = lp ? 1 : 0;
      m_jreq = m_rise[1] | (m_jreq & ~tick);
      e = {m_owner == 1, m_owner == 2, ~m_deb[1], m_jreq, ~(&m_deb)};

      m_win.push_back(m_s2);
      if (m_win.size() > DEB) void'(m_win.pop_front());
      nd = m_deb;
      for (int i = 0; i < 3; i++) begin
        if (m_win.size() == DEB) begin
          all_diff = 1'b1;
          foreach (m_win[j]) if (m_win[j][i] == m_deb[i]) all_diff = 1'b0;
          if (all_diff) nd[i] = ~m_deb[i];
        end
      end
      m_rise = m_deb & ~nd;
      m_deb  = nd;
      m_s2 = m_s1;
      m_s1 = kn;
    end
    sb.push_back(e);
  endtask

  always @(posedge clk) model_edge(key_n, game_tick, rst);

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [4:0] e, a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = {move_left, move_right, jump, jump_req, any_input_level};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL scoreboard t=%0t got {ml,mr,j,jr,any}=%b expected %b", $time, a, e);
      end
      vectors++;
      if (move_left && move_right) begin
        miscompares++;
        $display("FAIL dir_exclusive t=%0t got ml=1 mr=1 expected at most one", $time);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic chk(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Apply kn/tick for n cycles; returns 1 time unit after the last rising edge
  task automatic step(input logic [2:0] kn, input logic tick, input int n);
    repeat (n) begin
      @(negedge clk);
      key_n = kn;
      game_tick = tick;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [2:0] kn;
    int hold;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_move_left", move_left, 1'b0);
    chk("reset_jump_req", jump_req, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Glitch rejection: 3-cycle jump pulse
    for (int i = 0; i < 11; i++) begin
      step((i < 3) ? 3'b101 : 3'b111, 1'b0, 1);
      chk("glitch_jump", jump, 1'b0);
      chk("glitch_jump_req", jump_req, 1'b0);
      chk("glitch_any", any_input_level, 1'b0);
    end

    // Clean press: outputs at edge 7, request held until a tick
    step(3'b101, 1'b0, 6);
    chk("press_edge6_jump", jump, 1'b0);
    step(3'b101, 1'b0, 1);
    chk("press_edge7_jump", jump, 1'b1);
    chk("press_edge7_jump_req", jump_req, 1'b1);
    step(3'b101, 1'b0, 3);
    chk("press_hold_jump_req", jump_req, 1'b1);
    step(3'b101, 1'b1, 1);
    chk("press_consumed_jump_req", jump_req, 1'b0);
    chk("press_consumed_jump", jump, 1'b1);

    // Coincident press edge and consuming tick
    step(3'b111, 1'b0, 8);
    chk("coin_release_jump", jump, 1'b0);
    step(3'b101, 1'b0, 7);
    step(3'b111, 1'b0, 8);
    chk("coin_pending_jump_req", jump_req, 1'b1);
    step(3'b101, 1'b0, 6);
    step(3'b101, 1'b1, 1);
    chk("coin_edge_jump_req", jump_req, 1'b1);
    chk("coin_edge_jump", jump, 1'b1);
    step(3'b101, 1'b1, 1);
    chk("coin_next_tick_jump_req", jump_req, 1'b0);

    // Direction override
    step(3'b111, 1'b0, 8);
    step(3'b011, 1'b0, 6);
    chk("left_edge6", move_left, 1'b0);
    step(3'b011, 1'b0, 1);
    chk("left_edge7", move_left, 1'b1);
    step(3'b010, 1'b0, 6);
    chk("override_edge6_left", move_left, 1'b1);
    step(3'b010, 1'b0, 1);
    chk("override_right", move_right, 1'b1);
    chk("override_left_off", move_left, 1'b0);
    step(3'b011, 1'b0, 6);
    chk("revert_edge6_right", move_right, 1'b1);
    step(3'b011, 1'b0, 1);
    chk("revert_left", move_left, 1'b1);
    chk("revert_right_off", move_right, 1'b0);

    // any_input with simultaneous left+right
    step(3'b111, 1'b0, 8);
    step(3'b010, 1'b0, 7);
    chk("both_any", any_input_level, 1'b1);
    chk("both_one_dir", move_left ^ move_right, 1'b1);

    // Reset mid-debounce
    step(3'b000, 1'b0, 8);
    chk("pre_reset_any", any_input_level, 1'b1);
    step(3'b110, 1'b0, 3);
    #1;
    rst = 1'b0;
    sb.delete();
    #1;
    chk("async_reset_outputs", |{move_left, move_right, jump, jump_req, any_input_level}, 1'b0);
    step(3'b110, 1'b0, 2);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    step(3'b110, 1'b0, 5);
    chk("post_reset_edge6_right", move_right, 1'b0);
    step(3'b110, 1'b0, 1);
    chk("post_reset_edge7_right", move_right, 1'b1);

    // Randomized holds, checked by the scoreboard
    for (int s = 0; s < 150; s++) begin
      kn = 3'($urandom_range(0, 7));
      hold = int'($urandom_range(1, 9));
      for (int c = 0; c < hold; c++) step(kn, ($urandom_range(0, 4) == 0), 1);
    end

    step(3'b111, 1'b0, 3);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_platform_input_conditioner
